// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor: operation select,
// controller states and the bit-counter width helper.
package serial_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-bit operation still needs a one-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_cell.sv
// One-bit full adder / full subtractor built from 2:1 muxes.
// The sum and difference bits are identical; only the carry/borrow differs.
module addsub_cell
    import serial_addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic c,
    input  logic op,
    output logic s,
    output logic co
);

    logic p;
    logic add_co;
    logic sub_bo;

    assign p = x ? ~y : y;
    assign s = c ? ~p : p;

    // When x and y differ, the add carry follows c and the borrow follows y;
    // when they match, the carry is x and the borrow is c.
    assign add_co = p ? c : x;
    assign sub_bo = p ? y : c;

    assign co = (op == OP_SUB) ? sub_bo : add_co;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per cycle, LSB first, using a single
// shared add/sub cell and a registered carry/borrow.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic             op_q, op_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             cell_s;
    logic             cell_co;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    addsub_cell u_cell (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .c  (carry_q),
        .op (op_q),
        .s  (cell_s),
        .co (cell_co)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        accept   = 1'b0;
        res_next = res_sh_q >> 1;
        res_next[WIDTH-1] = cell_s;

        case (state_q)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next;
                carry_d  = cell_co;
                cnt_d    = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d  = DONE;
                    result_d = res_next;
                    cout_d   = cell_co;
                    // cell_s here is the final result MSB.
                    if (op_q == OP_ADD) begin
                        ovf_d = (a_msb_q == b_msb_q) && (cell_s != a_msb_q);
                    end else begin
                        ovf_d = (a_msb_q != b_msb_q) && (cell_s != a_msb_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                accept  = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            a_sh_d  = a;
            b_sh_d  = b;
            op_d    = op;
            carry_d = cin;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: an 8-bit and a 1-bit instance checked every cycle
// against an arithmetic model, plus hand-computed directed vectors.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, start8, op8, cin8;
    logic [7:0] a8, b8, res8;
    logic       busy8, done8, cout8, ovf8;

    logic       rst1, start1, op1, cin1;
    logic [0:0] a1, b1, res1;
    logic       busy1, done1, cout1, ovf1;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .op(op8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8),
        .cout(cout8), .overflow(ovf8)
    );

    serial_addsub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .op(op1), .cin(cin1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .result(res1),
        .cout(cout1), .overflow(ovf1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome from plain integer arithmetic on the operand values.
    function automatic void calc(input int w, input bit op_v, input bit ci,
                                 input longint av, input longint bv,
                                 output longint r, output bit co, output bit ov);
        longint m, half, sa, sb, sr, c;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        c    = ci ? 1 : 0;
        av   = av & m;
        bv   = bv & m;
        sa   = (av >= half) ? av - (m + 1) : av;
        sb   = (bv >= half) ? bv - (m + 1) : bv;
        if (op_v == OP_SUB) begin
            r  = (av - bv - c) & m;
            co = (av < bv + c);
            sr = sa - sb - c;
        end else begin
            r  = (av + bv + c) & m;
            co = (((av + bv + c) >> w) & 1) != 0;
            sr = sa + sb + c;
        end
        ov = (sr > half - 1) || (sr < -half);
    endfunction

    // Model state per instance: remaining RUN cycles, done flag, held outputs.
    int     left [2];
    bit     mdone[2];
    longint mres [2];
    bit     mc   [2];
    bit     mo   [2];
    longint pres [2];
    bit     pc   [2];
    bit     po   [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            left[k] = 0; mdone[k] = 0; mres[k] = 0; mc[k] = 0; mo[k] = 0;
            pres[k] = 0; pc[k] = 0; po[k] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit     r_i, s_i, o_i, c_i;
            longint a_v, b_v;
            int     w;
            w   = (k == 0) ? 8 : 1;
            r_i = (k == 0) ? rst8 : rst1;
            s_i = (k == 0) ? start8 : start1;
            o_i = (k == 0) ? op8 : op1;
            c_i = (k == 0) ? cin8 : cin1;
            a_v = (k == 0) ? longint'(a8) : longint'(a1);
            b_v = (k == 0) ? longint'(b8) : longint'(b1);
            if (r_i) begin
                left[k] = 0; mdone[k] = 0; mres[k] = 0; mc[k] = 0; mo[k] = 0;
            end else if (left[k] > 0) begin
                left[k]--;
                if (left[k] == 0) begin
                    mdone[k] = 1;
                    mres[k]  = pres[k];
                    mc[k]    = pc[k];
                    mo[k]    = po[k];
                end
            end else begin
                mdone[k] = 0;
                if (s_i) begin
                    left[k] = w;
                    calc(w, o_i, c_i, a_v, b_v, pres[k], pc[k], po[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m8_busy", busy8, left[0] > 0);
            check("m8_done", done8, mdone[0]);
            check("m8_result", res8, mres[0]);
            check("m8_cout", cout8, mc[0]);
            check("m8_ovf", ovf8, mo[0]);
            check("m1_busy", busy1, left[1] > 0);
            check("m1_done", done1, mdone[1]);
            check("m1_result", res1, mres[1]);
            check("m1_cout", cout1, mc[1]);
            check("m1_ovf", ovf1, mo[1]);
        end
    end

    // Called at a negedge: present the request for one cycle.
    task automatic go(input int k, input bit op_v, input bit ci, input logic [7:0] av, input logic [7:0] bv);
        if (k == 0) begin
            start8 = 1; op8 = op_v; cin8 = ci; a8 = av; b8 = bv;
        end else begin
            start1 = 1; op1 = op_v; cin1 = ci; a1 = av[0]; b1 = bv[0];
        end
        @(negedge clk);
        start8 = 0;
        start1 = 0;
    endtask

    // Waits for done, checking latency and literal results; optionally pulses
    // start with other operands n cycles into RUN.
    task automatic wait_done(input int k, input string tag, input logic [7:0] er,
                             input bit ec, input bit eo, input int pulse_at);
        int n;
        bit seen;
        int w;
        n = 0; seen = 0;
        w = (k == 0) ? 8 : 1;
        while (n <= 40 && !seen) begin
            if ((k == 0) ? done8 : done1) begin
                seen = 1;
            end else begin
                check($sformatf("%s_busy", tag), (k == 0) ? busy8 : busy1, 1);
                if (k == 0 && n == pulse_at) begin
                    start8 = 1; a8 = 8'hAA; b8 = 8'h55; op8 = ~op8; cin8 = ~cin8;
                end
                if (k == 0 && n == pulse_at + 1) start8 = 0;
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            check($sformatf("%s_timeout", tag), 0, 1);
        end else begin
            check($sformatf("%s_latency", tag), n, w);
            if (k == 0) begin
                check($sformatf("%s_result", tag), res8, er);
                check($sformatf("%s_cout", tag), cout8, ec);
                check($sformatf("%s_ovf", tag), ovf8, eo);
            end else begin
                check($sformatf("%s_result", tag), res1, er[0]);
                check($sformatf("%s_cout", tag), cout1, ec);
                check($sformatf("%s_ovf", tag), ovf1, eo);
            end
        end
    endtask

    typedef struct {
        bit         op_v;
        bit         ci;
        logic [7:0] av;
        logic [7:0] bv;
        logic [7:0] r;
        bit         co;
        bit         ov;
    } vec_t;

    vec_t vt[8] = '{
        '{1'b0, 1'b0, 8'h3C, 8'h45, 8'h81, 1'b0, 1'b1},
        '{1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0},
        '{1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0},
        '{1'b1, 1'b1, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b1},
        '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1},
        '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0},
        '{1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0},
        '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0}
    };

    initial begin
        rst8 = 1; start8 = 0; op8 = 0; cin8 = 0; a8 = 0; b8 = 0;
        rst1 = 1; start1 = 0; op1 = 0; cin1 = 0; a1 = 0; b1 = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        check("rst8_busy", busy8, 0);
        check("rst8_done", done8, 0);
        check("rst8_result", res8, 0);
        check("rst8_cout", cout8, 0);
        check("rst8_ovf", ovf8, 0);
        check("rst1_result", res1, 0);
        rst8 = 0;
        rst1 = 0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            go(0, vt[i].op_v, vt[i].ci, vt[i].av, vt[i].bv);
            wait_done(0, $sformatf("vec%0d", i), vt[i].r, vt[i].co, vt[i].ov, -1);
            $display("vec%0d op=%0d cin=%0d a=%h b=%h -> result=%h cout=%0d ovf=%0d",
                     i, vt[i].op_v, vt[i].ci, vt[i].av, vt[i].bv, res8, cout8, ovf8);
        end

        // start during RUN is ignored; start in the DONE cycle is accepted.
        @(negedge clk);
        go(0, OP_ADD, 1'b0, 8'h11, 8'h22);
        wait_done(0, "ignore", 8'h33, 1'b0, 1'b0, 3);
        $display("ignore-start: result=%h", res8);
        go(0, OP_ADD, 1'b0, 8'h01, 8'h01);
        wait_done(0, "b2b", 8'h02, 1'b0, 1'b0, -1);
        $display("back-to-back: result=%h", res8);

        // Reset in the 4th RUN cycle aborts without a done pulse.
        @(negedge clk);
        go(0, OP_ADD, 1'b0, 8'h11, 8'h22);
        repeat (3) @(negedge clk);
        rst8 = 1;
        @(negedge clk);
        rst8 = 0;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_result", res8, 0);
        check("abort_cout", cout8, 0);
        check("abort_ovf", ovf8, 0);
        for (int i = 0; i < 12; i++) begin
            check("abort_nodone", done8, 0);
            @(negedge clk);
        end
        $display("reset-abort: busy=%0d done=%0d result=%h", busy8, done8, res8);
        go(0, OP_ADD, 1'b0, 8'h05, 8'h03);
        wait_done(0, "after_rst", 8'h08, 1'b0, 1'b0, -1);
        $display("after-reset: result=%h", res8);

        // Single-bit instance.
        go(1, OP_SUB, 1'b0, 8'h00, 8'h01);
        wait_done(1, "w1_sub", 8'h01, 1'b1, 1'b1, -1);
        $display("w1 sub 0-1: result=%0d cout=%0d ovf=%0d", res1, cout1, ovf1);
        go(1, OP_ADD, 1'b0, 8'h01, 8'h01);
        wait_done(1, "w1_add", 8'h00, 1'b1, 1'b1, -1);
        $display("w1 add 1+1: result=%0d cout=%0d ovf=%0d", res1, cout1, ovf1);
        go(1, OP_ADD, 1'b1, 8'h00, 8'h00);
        wait_done(1, "w1_cin", 8'h01, 1'b0, 1'b1, -1);
        $display("w1 add 0+0+1: result=%0d cout=%0d ovf=%0d", res1, cout1, ovf1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor, the sequential successor to the team's mux-based half/full adder and subtractor cells. A WIDTH-bit operation is computed one bit per cycle, LSB first. One mux-based add/sub bit cell is reused every cycle, with a registered carry/borrow. It sits in the datapath as a low-area ALU slave driven by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, request pulse; sampled only when idle or in DONE.
- op, input, 1, 0 = add, 1 = subtract; latched on accepted start.
- cin, input, 1, carry-in (add) or borrow-in (sub); latched on accepted start.
- a, input, WIDTH, operand A; latched on accepted start.
- b, input, WIDTH, operand B; latched on accepted start.
- busy, output, 1, high while an operation is in RUN.
- done, output, 1, one-cycle pulse when result/cout/overflow become valid.
- result, output, WIDTH, add: a+b+cin mod 2^WIDTH; sub: a-b-cin mod 2^WIDTH.
- cout, output, 1, add: carry out of MSB; sub: borrow out (1 iff a < b+cin, unsigned).
- overflow, output, 1, signed overflow (two's complement).

Behaviour:
- Reset (synchronous, rst=1 at edge): state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0, bit counter=0, internal shift and carry registers=0. Reset overrides start. Reset mid-RUN aborts the operation with no done pulse.
- States:
  - IDLE: start=1 latches a, b, op, cin into operand shift registers and the carry FF; counter=0; next state RUN.
  - RUN: busy=1. Each cycle the cell computes the bit from the LSB of a_sh, the LSB of b_sh, and the carry (op selects add or sub). The sum/diff bit shifts into the MSB of the result shift register; the carry FF updates; a_sh and b_sh shift right; counter increments. When counter==WIDTH-1, the next state is DONE.
  - DONE: done=1 and busy=0 for exactly one cycle. result, cout and overflow registers load at the RUN->DONE edge and hold until the next operation's DONE or reset. Next state is IDLE, or RUN if start=1 in this cycle (back-to-back accepted).
- start while in RUN is ignored; latched operands are unaffected by input changes after acceptance.
- Latency: start accepted at cycle t -> busy in cycles t+1..t+WIDTH -> done=1 in cycle t+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- overflow is computed from the latched MSBs of a and b and the final result MSB:
  - add: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - sub: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
- WIDTH=1: RUN lasts a single cycle; counter width is max(1, clog2(WIDTH)).
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package serial_addsub_pkg holds:
  - op encoding constants OP_ADD=1'b0 and OP_SUB=1'b1;
  - the state encoding IDLE/RUN/DONE.
- One sub-module, addsub_cell: combinational 1-bit full adder/full subtractor built from 2:1 muxes.
  - Inputs: x, y, c, op. Outputs: s, co.
  - Sub borrow = (~x & y) | (c & ~(x^y)).
  - Instantiated once in serial_addsub.

Test Plan:
1. WIDTH=8, op=ADD, a=8'h3C, b=8'h45, cin=0, start at t -> done only at t+9; result=8'h81, cout=0, overflow=1; busy high t+1..t+8.
2. op=SUB, a=8'h10, b=8'h20, cin=0 -> result=8'hF0, cout=1 (borrow), overflow=0.
3. op=ADD, a=8'hFF, b=8'h01, cin=1 -> result=8'h01, cout=1, overflow=0.
4. Pulse start again during RUN with different operands -> ignored, result unchanged. Assert start in the DONE cycle (ADD 8'h01+8'h01) -> accepted; second done 9 cycles later with result=8'h02.
5. Assert rst at the 4th RUN cycle -> next cycle busy=0, done=0, result=0, cout=0, overflow=0; no done pulse follows. A subsequent ADD 8'h05+8'h03 yields 8'h08.
6. WIDTH=1 instance, op=SUB, a=0, b=1, cin=0 -> done at t+2, result=1, cout=1, overflow=1.
